// File: rtl/lamp_sequencer.sv
// lamp_sequencer: steps a 16-lamp thermometer bar one lamp per prescaled tick
// toward the target count of the current phase, and pulses check with the
// completed phase number when the bar is already at target on a tick.
module lamp_sequencer #(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  mode,
  output logic [15:0] lamp,
  output logic        check,
  output logic [2:0]  prev_mode
);

  localparam int unsigned COUNT_W = 5;
  localparam int unsigned PRESC_W = 8;
  localparam int unsigned MODE_W  = 3;
  localparam int unsigned LAMP_N  = 16;
  localparam int unsigned DEC_W   = LAMP_N + 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYCLES - 1);

  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_nxt;
  logic [COUNT_W-1:0] target;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_nxt;
  logic               check_nxt;
  logic [MODE_W-1:0]  prev_mode_nxt;
  logic               tick;

  // Phase target lookup; invalid phases 6 and 7 drive the bar to empty.
  always_comb begin
    target = '0;
    case (mode)
      3'd1:    target = COUNT_W'(16);
      3'd2:    target = COUNT_W'(5);
      3'd3:    target = COUNT_W'(10);
      3'd5:    target = COUNT_W'(5);
      default: target = '0;
    endcase
  end

  // Step strobe: last prescaler cycle while enabled.
  always_comb begin
    tick = en && (presc == PRESC_LAST);
  end

  // Next-state: prescaler advance, one-lamp step toward target, check pulse.
  always_comb begin
    presc_nxt     = presc;
    count_nxt     = count;
    check_nxt     = 1'b0;
    prev_mode_nxt = prev_mode;
    if (en) begin
      if (tick) begin
        presc_nxt = '0;
        if (count < target) begin
          count_nxt = count + COUNT_W'(1);
        end else if (count > target) begin
          count_nxt = count - COUNT_W'(1);
        end else if (!check) begin
          // A held phase at STEP_CYCLES = 1 ticks every cycle; suppressing
          // the back-to-back case keeps check a single-cycle pulse.
          check_nxt     = 1'b1;
          prev_mode_nxt = mode;
        end
      end else begin
        presc_nxt = presc + PRESC_W'(1);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      count     <= '0;
      check     <= 1'b0;
      prev_mode <= '0;
    end else begin
      presc     <= presc_nxt;
      count     <= count_nxt;
      check     <= check_nxt;
      prev_mode <= prev_mode_nxt;
    end
  end

  // Thermometer decode of the registered count; count = 16 lights all lamps.
  always_comb begin
    lamp = LAMP_N'((DEC_W'(1) << count) - DEC_W'(1));
  end

endmodule
